// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth sequential multiplier.
package booth_pkg;

    localparam int unsigned W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/booth_step.sv
// One Booth iteration: conditional add/subtract of x, then arithmetic shift of {A,Q,q_1}.
module booth_step #(
    parameter int unsigned W = 8
) (
    input  logic [W:0]   a,
    input  logic [W-1:0] q,
    input  logic         q_1,
    input  logic [W-1:0] x,
    output logic [W:0]   a_c,
    output logic [W-1:0] q_c,
    output logic         q1_c
);

    logic [W:0] x_ext;
    logic [W:0] a_sum;

    assign x_ext = {x[W-1], x};

    always_comb begin
        a_sum = a;
        case ({q[0], q_1})
            2'b01:   a_sum = a + x_ext;
            2'b10:   a_sum = a - x_ext;
            default: a_sum = a;
        endcase
    end

    assign a_c  = {a_sum[W], a_sum[W:1]};
    assign q_c  = {a_sum[0], q[W-1:1]};
    assign q1_c = q[0];

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential signed multiplier: one Booth step per cycle over W cycles, result held until next done.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] ans
);

    localparam int unsigned CW = $clog2(W + 1);

    state_t        state;
    state_t        state_nxt;
    logic [W:0]    a_r;
    logic [W-1:0]  q_r;
    logic          q1_r;
    logic [W-1:0]  x_r;
    logic [CW-1:0] cnt;

    logic [W:0]    a_c;
    logic [W-1:0]  q_c;
    logic          q1_c;

    logic          last;
    logic          load;
    logic          ans_en;
    logic          busy_d;
    logic          done_d;

    booth_step #(.W(W)) u_step (
        .a    (a_r),
        .q    (q_r),
        .q_1  (q1_r),
        .x    (x_r),
        .a_c  (a_c),
        .q_c  (q_c),
        .q1_c (q1_c)
    );

    assign last = (cnt == CW'(W - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control decode; busy/done are registered from the state being entered
    always_comb begin
        load   = 1'b0;
        ans_en = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        if (state == IDLE && start) load = 1'b1;
        if (state == CALC && last) ans_en = 1'b1;
        if (state_nxt == CALC) busy_d = 1'b1;
        if (state_nxt == DONE) done_d = 1'b1;
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r  <= '0;
            q_r  <= '0;
            q1_r <= 1'b0;
            x_r  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            ans  <= '0;
        end else begin
            busy <= busy_d;
            done <= done_d;
            if (load) begin
                a_r  <= '0;
                q_r  <= y;
                q1_r <= 1'b0;
                x_r  <= x;
                cnt  <= '0;
            end else if (state == CALC) begin
                a_r  <= a_c;
                q_r  <= q_c;
                q1_r <= q1_c;
                cnt  <= cnt + CW'(1);
            end
            if (ans_en) ans <= {a_c[W-1:0], q_c};
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq at W=4 and W=8 against a signed arithmetic model.
module tb_booth_mult_seq;

    logic        clk = 1'b0;
    logic        rst4_n, rst8_n;
    logic        start4, start8;
    logic [3:0]  x4, y4;
    logic [7:0]  x8, y8;
    logic        busy4, done4, busy8, done8;
    logic [7:0]  ans4;
    logic [15:0] ans8;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    booth_mult_seq #(.W(4)) u_dut4 (
        .clk(clk), .rst_n(rst4_n), .start(start4), .x(x4), .y(y4),
        .busy(busy4), .done(done4), .ans(ans4)
    );

    booth_mult_seq #(.W(8)) u_dut8 (
        .clk(clk), .rst_n(rst8_n), .start(start8), .x(x8), .y(y8),
        .busy(busy8), .done(done8), .ans(ans8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref4(input logic [3:0] a, input logic [3:0] b);
        int sa, sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        return 8'(sa * sb);
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b);
        int sa, sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        return 16'(sa * sb);
    endfunction

    // Call at a negedge with the DUT idle; start is presented immediately.
    task automatic mul4(input logic [3:0] a, input logic [3:0] b,
                        output logic [7:0] res, output int lat, output int bcnt);
        x4 = a; y4 = b; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0; x4 = ~a; y4 = ~b;
        lat = 0; bcnt = 0;
        while (lat < 40) begin
            @(negedge clk); lat++;
            if (busy4) bcnt++;
            if (done4) break;
        end
        res = ans4;
    endtask

    task automatic mul8(input logic [7:0] a, input logic [7:0] b, input bit repulse,
                        input logic [15:0] prev, output logic [15:0] res, output int lat,
                        output int bcnt, output logic [15:0] held);
        x8 = a; y8 = b; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; x8 = ~a; y8 = b ^ 8'h5A;
        lat = 0; bcnt = 0; held = prev;
        while (lat < 40) begin
            @(negedge clk); lat++;
            if (repulse && lat == 2) begin
                start8 = 1'b1; x8 = 8'd1; y8 = 8'd1;
            end else if (repulse && lat == 3) begin
                start8 = 1'b0;
            end
            if (busy8) bcnt++;
            if (done8) break;
            if (ans8 !== prev && held === prev) held = ans8;
        end
        res = ans8;
    endtask

    initial begin
        logic [7:0]  r4;
        logic [15:0] r8, held, prev8;
        logic [3:0]  a4, b4;
        logic [7:0]  a8, b8;
        int lat, bcnt, ndone;

        rst4_n = 1'b0; rst8_n = 1'b0;
        start4 = 1'b0; start8 = 1'b0;
        x4 = '0; y4 = '0; x8 = '0; y8 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy4", busy4, 0);
        check("rst_done4", done4, 0);
        check("rst_ans4", ans4, 0);
        check("rst_busy8", busy8, 0);
        check("rst_done8", done8, 0);
        check("rst_ans8", ans8, 0);

        // Start presented together with reset release: accepted on the first edge
        rst4_n = 1'b1; rst8_n = 1'b1;
        mul4(4'd3, 4'd5, r4, lat, bcnt);
        check("w4_3x5_ans", r4, 8'h0F);
        check("w4_3x5_lat", lat, 5);
        check("w4_3x5_busy", bcnt, 4);

        @(negedge clk); mul4(4'h8, 4'h2, r4, lat, bcnt);
        check("w4_m8x2", r4, 8'hF0);
        @(negedge clk); mul4(4'h8, 4'h8, r4, lat, bcnt);
        check("w4_m8xm8", r4, 8'h40);
        @(negedge clk); mul4(4'hF, 4'hF, r4, lat, bcnt);
        check("w4_m1xm1", r4, 8'h01);
        @(negedge clk);
        check("w4_done_pulse", done4, 0);
        check("w4_hold", ans4, 8'h01);

        // Exhaustive W=4 sweep
        for (int i = 0; i < 256; i++) begin
            a4 = 4'(i >> 4);
            b4 = 4'(i);
            @(negedge clk); mul4(a4, b4, r4, lat, bcnt);
            check("w4_sweep", r4, ref4(a4, b4));
            if (lat != 5) check("w4_sweep_lat", lat, 5);
        end

        // Restart request during CALC must be ignored
        mul8(8'd100, 8'hFD, 1'b1, 16'h0000, r8, lat, bcnt, held);
        check("w8_repulse_ans", r8, 16'hFED4);
        check("w8_repulse_lat", lat, 9);
        check("w8_repulse_busy", bcnt, 8);
        ndone = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        check("w8_repulse_extra_done", ndone, 0);
        check("w8_repulse_hold", ans8, 16'hFED4);

        @(negedge clk); mul8(8'h80, 8'h80, 1'b0, 16'hFED4, r8, lat, bcnt, held);
        check("w8_min_sq", r8, 16'h4000);
        @(negedge clk); mul8(8'hFF, 8'hFF, 1'b0, 16'h4000, r8, lat, bcnt, held);
        check("w8_m1xm1", r8, 16'h0001);
        check("w8_hold_between", held, 16'h4000);

        // Reset mid-operation at iteration 4
        @(negedge clk);
        x8 = 8'd55; y8 = 8'd77; start8 = 1'b1;
        @(posedge clk); #1; start8 = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy_before", busy8, 1);
        rst8_n = 1'b0;
        #1;
        check("mid_rst_busy", busy8, 0);
        check("mid_rst_ans", ans8, 0);
        check("mid_rst_done", done8, 0);
        @(negedge clk);
        check("mid_rst_hold_ans", ans8, 0);
        rst8_n = 1'b1;
        mul8(8'd7, 8'd6, 1'b0, 16'h0000, r8, lat, bcnt, held);
        check("after_rst_ans", r8, 16'h002A);
        check("after_rst_lat", lat, 9);
        check("after_rst_no_stray", held, 16'h0000);

        // Randomized W=8 against the signed model, with hold check between results
        prev8 = 16'h002A;
        for (int i = 0; i < 1000; i++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            if (i % 50 == 0) a8 = 8'h00;
            if (i % 50 == 1) b8 = 8'hFF;
            @(negedge clk); mul8(a8, b8, 1'b0, prev8, r8, lat, bcnt, held);
            check("rand8_ans", r8, ref8(a8, b8));
            check("rand8_hold", held, prev8);
            if (lat != 9) check("rand8_lat", lat, 9);
            prev8 = ref8(a8, b8);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/booth_mult_seq.md
BOOTH_MULT_SEQ -- requirements
Module: booth_mult_seq

Interface
REQ-001 SHALL have parameter: W, 8, operand width in bits, legal range 4..32.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request a multiply; sampled only in IDLE.
REQ-005 SHALL have port: x  input  W  multiplicand, two's complement signed.
REQ-006 SHALL have port: y  input  W  multiplier, two's complement signed.
REQ-007 SHALL have port: busy  output  1  high while a multiply is in progress (CALC).
REQ-008 SHALL have port: done  output  1  one-cycle pulse marking ans valid for a new result.
REQ-009 SHALL have port: ans  output  2W  signed product x*y.

Function
REQ-010 SHALL implement a radix-2 Booth sequential multiplier with FSM states IDLE, CALC and DONE.
REQ-011 SHALL register x and y on the clock edge where start=1 in IDLE; later operand changes SHALL NOT affect that result.
REQ-012 SHALL, on accept, load accumulator A (W+1 bits)=0, Q=y, q_1=0 and iteration counter=0, then enter CALC.
REQ-013 SHALL, each CALC cycle, examine {Q[0],q_1}: 01 -> A+=sext(x), 10 -> A-=sext(x), 00/11 -> no add; then arithmetic-shift {A,Q,q_1} right by 1.
REQ-014 SHALL size A at W+1 bits so that subtracting x=-2^(W-1) does not overflow.
REQ-015 SHALL perform exactly W CALC iterations, then enter DONE.
REQ-016 SHALL, in DONE, drive ans={A[W-1:0],Q}, assert done for exactly that one cycle, and return to IDLE next cycle.
REQ-017 SHALL have latency: start accepted at edge N -> done high in cycle N+W+1; the next start is accepted no earlier than edge N+W+2.
REQ-018 SHALL hold ans stable at the last result from DONE until the next DONE.
REQ-019 SHALL ignore start while busy=1 or done=1 (no queueing, no abort).
REQ-020 SHALL hold busy=1 exactly during the W CALC cycles.
REQ-021 SHALL produce 2^(2W-2) for x=y=-2^(W-1) without wrap.
REQ-022 SHALL yield the correct product for every operand pair, including zero and all-ones operands.

Reset
REQ-023 SHALL, on rst_n=0, asynchronously force state=IDLE, busy=0, done=0, ans=0 and clear A, Q, q_1 and the counter.
REQ-024 SHALL abort any multiply in progress on reset mid-operation, with no done pulse for it.
REQ-025 SHALL be able to accept start on the first rising edge after rst_n deasserts.

Structure
REQ-026 SHALL place the FSM state enumeration and the default W constant in shared package booth_pkg.
REQ-027 SHALL isolate one iteration (add/sub select plus arithmetic shift) in combinational sub-module booth_step, parametrised by W.
REQ-028 SHALL size the iteration counter at $clog2(W+1) bits.

Verification
REQ-029 SHALL verify with W=4, x=3, y=5, start pulse -> done in cycle 5 after accept, ans=8'h0F.
REQ-030 SHALL verify with W=4, x=4'h8 (-8), y=2 -> ans=8'hF0 (-16).
REQ-031 SHALL verify with W=4, x=y=4'h8 -> ans=8'h40 (+64); with x=4'hF, y=4'hF -> ans=8'h01.
REQ-032 SHALL verify with W=8, x=100, y=-3, and start re-pulsed with x=1, y=1 during CALC -> ans=16'hFED4, second request ignored, one done pulse.
REQ-033 SHALL verify with W=8: rst_n low for one cycle at iteration 4 -> busy=0, ans=0, no done; a new start with x=7, y=6 then gives ans=16'h002A.
REQ-034 SHALL verify randomized W=8 operands against a signed reference model (1000 vectors), checking that ans is unchanged between done pulses.
